// File: rtl/gate_bist_pkg.sv
// Shared encodings and the golden truth table for the two-input gate BIST.
package gate_bist_pkg;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_NAND = 3'd2;
    localparam logic [2:0] OP_NOR  = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;

    localparam int unsigned NUM_PATTERNS = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    function automatic logic golden(input logic [2:0] op, input logic a, input logic b);
        logic y;
        case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_NAND: y = ~(a & b);
            OP_NOR:  y = ~(a | b);
            OP_XOR:  y = a ^ b;
            OP_XNOR: y = ~(a ^ b);
            default: y = 1'b0;
        endcase
        return y;
    endfunction

    // Counter width that never collapses to zero bits for a count of one.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gate_bist_golden.sv
// Combinational truth-table lookup giving the expected gate output for (op, a, b).
module gate_bist_golden
    import gate_bist_pkg::*;
(
    input  logic [2:0] op,
    input  logic       a,
    input  logic       b,
    output logic       y_exp
);

    assign y_exp = golden(op, a, b);

endmodule

// File: rtl/gate_bist.sv
// BIST sequencer: sweeps a/b through 00,01,10,11, checks y against the golden table.
// Optional first-mismatch capture enabled by GATE_BIST_FAIL_CAPTURE_EN.
//
// state  | meaning
// IDLE   | waiting for start
// SETTLE | pattern held on dut_a/dut_b while the gate output settles
// CHECK  | dut_y compared with the golden value, advance pattern/pass
// DONE   | one-cycle done pulse, pass/fail_count valid
module gate_bist
    import gate_bist_pkg::*;
#(
    parameter int unsigned GATE_OP       = 2,
    parameter int unsigned NUM_PASSES    = 1,
    parameter int unsigned SETTLE_CYCLES = 1,
    localparam int unsigned FCW = $clog2(4 * NUM_PASSES + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    output logic           dut_a,
    output logic           dut_b,
    input  logic           dut_y,
    output logic           busy,
    output logic           done,
    output logic           pass,
    output logic [FCW-1:0] fail_count,
    output logic [2:0]     first_fail
);

    localparam int unsigned SCW = cnt_width(SETTLE_CYCLES);
    localparam int unsigned PIW = cnt_width(NUM_PASSES);

    state_t         state_q;
    state_t         state_d;
    logic [1:0]     pat_q;
    logic [PIW-1:0] pidx_q;
    logic [SCW-1:0] settle_q;
    logic [FCW-1:0] fail_q;
    logic           busy_q;
    logic           done_q;
    logic           pass_q;

    logic y_exp;
    logic mismatch;
    logic settle_last;
    logic sweep_last;
    logic accept;

    gate_bist_golden u_golden (
        .op    (3'(GATE_OP)),
        .a     (pat_q[1]),
        .b     (pat_q[0]),
        .y_exp (y_exp)
    );

    assign accept      = (state_q == ST_IDLE) && start;
    assign mismatch    = (state_q == ST_CHECK) && (dut_y != y_exp);
    assign settle_last = (settle_q == SCW'(SETTLE_CYCLES - 1));
    assign sweep_last  = (pat_q == 2'd3) && (pidx_q == PIW'(NUM_PASSES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start) state_d = ST_SETTLE;
            ST_SETTLE: if (settle_last) state_d = ST_CHECK;
            ST_CHECK:  state_d = sweep_last ? ST_DONE : ST_SETTLE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pat_q    <= 2'd0;
            pidx_q   <= '0;
            settle_q <= '0;
            fail_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        pat_q    <= 2'd0;
                        pidx_q   <= '0;
                        settle_q <= '0;
                        fail_q   <= '0;
                        pass_q   <= 1'b0;
                        busy_q   <= 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (!settle_last) settle_q <= settle_q + SCW'(1);
                end
                ST_CHECK: begin
                    if (mismatch) fail_q <= fail_q + FCW'(1);
                    if (sweep_last) begin
                        // pass must include this final comparison, not just the registered count
                        pass_q <= (fail_q == '0) && !mismatch;
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        pat_q  <= 2'd0;
                        pidx_q <= '0;
                    end else begin
                        pat_q    <= pat_q + 2'd1;
                        settle_q <= '0;
                        if (pat_q == 2'd3) pidx_q <= pidx_q + PIW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign dut_a      = pat_q[1];
    assign dut_b      = pat_q[0];
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign fail_count = fail_q;

`ifdef GATE_BIST_FAIL_CAPTURE_EN
    logic [2:0] first_fail_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            first_fail_q <= 3'b000;
        end else if (accept) begin
            first_fail_q <= 3'b000;
        end else if (mismatch && !first_fail_q[2]) begin
            first_fail_q <= {1'b1, pat_q};
        end
    end

    assign first_fail = first_fail_q;
`else
    assign first_fail = 3'b000;
`endif

endmodule

// File: tb/tb_gate_bist.sv
// Self-checking bench: three gate_bist configurations driven by truth-table gate models.
`timescale 1ns/1ps
module tb_gate_bist;

    localparam int NI = 3;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic       rst_v   [NI];
    logic       start_v [NI];
    logic [3:0] tt      [NI];
    logic       a_w     [NI];
    logic       b_w     [NI];
    logic       y_w     [NI];
    logic       busy_w  [NI];
    logic       done_w  [NI];
    logic       pass_w  [NI];
    logic [2:0] ff_w    [NI];
    logic [3:0] fc      [NI];
    logic [2:0] fc0;
    logic [3:0] fc1;
    logic [2:0] fc2;

    assign fc[0] = {1'b0, fc0};
    assign fc[1] = fc1;
    assign fc[2] = {1'b0, fc2};

    assign y_w[0] = tt[0][{a_w[0], b_w[0]}];
    assign y_w[1] = tt[1][{a_w[1], b_w[1]}];
    assign y_w[2] = tt[2][{a_w[2], b_w[2]}];

    gate_bist #(.GATE_OP(2), .NUM_PASSES(1), .SETTLE_CYCLES(1)) u_nand (
        .clk(clk), .rst(rst_v[0]), .start(start_v[0]),
        .dut_a(a_w[0]), .dut_b(b_w[0]), .dut_y(y_w[0]),
        .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
        .fail_count(fc0), .first_fail(ff_w[0])
    );

    gate_bist #(.GATE_OP(3), .NUM_PASSES(2), .SETTLE_CYCLES(3)) u_nor (
        .clk(clk), .rst(rst_v[1]), .start(start_v[1]),
        .dut_a(a_w[1]), .dut_b(b_w[1]), .dut_y(y_w[1]),
        .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
        .fail_count(fc1), .first_fail(ff_w[1])
    );

    gate_bist #(.GATE_OP(5), .NUM_PASSES(1), .SETTLE_CYCLES(2)) u_xnor (
        .clk(clk), .rst(rst_v[2]), .start(start_v[2]),
        .dut_a(a_w[2]), .dut_b(b_w[2]), .dut_y(y_w[2]),
        .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]),
        .fail_count(fc2), .first_fail(ff_w[2])
    );

    logic [2:0] g_op;
    logic       g_a;
    logic       g_b;
    logic       g_y;

    gate_bist_golden u_gold (.op(g_op), .a(g_a), .b(g_b), .y_exp(g_y));

    // Truth tables indexed by {a,b}: bit i is the output for input pattern i.
    function automatic logic [3:0] ref_tt(input int op);
        case (op)
            0: return 4'b1000;
            1: return 4'b1110;
            2: return 4'b0111;
            3: return 4'b0001;
            4: return 4'b0110;
            5: return 4'b1001;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic int op_of(input int k);
        return (k == 0) ? 2 : (k == 1) ? 3 : 5;
    endfunction

    function automatic int s_of(input int k);
        return (k == 0) ? 1 : (k == 1) ? 3 : 2;
    endfunction

    function automatic int n_of(input int k);
        return (k == 1) ? 2 : 1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full run on instance k; checks timing, pattern order and results.
    task automatic sweep(input int k, input bit poke, input string tag);
        int         s, n, total, exp_fail, pat;
        logic [3:0] g;
        logic [2:0] exp_ff;
        s = s_of(k);
        n = n_of(k);
        total = 4 * n * (s + 1);
        g = ref_tt(op_of(k));
        exp_fail = 0;
        exp_ff = 3'b000;
        for (int p = 0; p < 4; p++) begin
            if (tt[k][p] !== g[p]) begin
                exp_fail += n;
                if (exp_ff[2] == 1'b0) exp_ff = {1'b1, 2'(p)};
            end
        end
`ifndef GATE_BIST_FAIL_CAPTURE_EN
        exp_ff = 3'b000;
`endif
        start_v[k] = 1'b1;
        tick();
        start_v[k] = 1'b0;
        for (int c = 1; c <= total; c++) begin
            pat = ((c - 1) / (s + 1)) % 4;
            checks++;
            if (busy_w[k] !== 1'b1 || done_w[k] !== 1'b0 || {a_w[k], b_w[k]} !== 2'(pat)) begin
                errors++;
                $display("FAIL %s run cycle %0d: busy=%b done=%b ab=%b%b, want busy=1 done=0 ab=%02b",
                         tag, c, busy_w[k], done_w[k], a_w[k], b_w[k], 2'(pat));
            end
            start_v[k] = poke && (c == total / 2);
            tick();
        end
        start_v[k] = 1'b0;
        checks++;
        if (done_w[k] !== 1'b1 || busy_w[k] !== 1'b0 || {a_w[k], b_w[k]} !== 2'b00) begin
            errors++;
            $display("FAIL %s done cycle %0d: done=%b busy=%b ab=%b%b, want done=1 busy=0 ab=00",
                     tag, total + 1, done_w[k], busy_w[k], a_w[k], b_w[k]);
        end
        checks++;
        if (pass_w[k] !== (exp_fail == 0)) begin
            errors++;
            $display("FAIL %s pass: got %b want %b", tag, pass_w[k], (exp_fail == 0));
        end
        checks++;
        if (fc[k] !== 4'(exp_fail)) begin
            errors++;
            $display("FAIL %s fail_count: got %0d want %0d", tag, fc[k], exp_fail);
        end
        checks++;
        if (ff_w[k] !== exp_ff) begin
            errors++;
            $display("FAIL %s first_fail: got %b want %b", tag, ff_w[k], exp_ff);
        end
        tick();
        checks++;
        if (done_w[k] !== 1'b0 || busy_w[k] !== 1'b0 || pass_w[k] !== (exp_fail == 0) || fc[k] !== 4'(exp_fail)) begin
            errors++;
            $display("FAIL %s after done: done=%b busy=%b pass=%b fc=%0d, want 0 0 %b %0d",
                     tag, done_w[k], busy_w[k], pass_w[k], fc[k], (exp_fail == 0), exp_fail);
        end
    endtask

    task automatic test_reset();
        for (int k = 0; k < NI; k++) begin
            rst_v[k] = 1'b1;
            start_v[k] = 1'b0;
        end
        tick();
        tick();
        for (int k = 0; k < NI; k++) begin
            checks++;
            if ({busy_w[k], done_w[k], pass_w[k], a_w[k], b_w[k], ff_w[k], fc[k]} !== 12'h000) begin
                errors++;
                $display("FAIL reset outputs inst %0d: busy=%b done=%b pass=%b ab=%b%b ff=%b fc=%0d, want all 0",
                         k, busy_w[k], done_w[k], pass_w[k], a_w[k], b_w[k], ff_w[k], fc[k]);
            end
            rst_v[k] = 1'b0;
        end
        tick();
    endtask

    task automatic test_golden_unit();
        logic [3:0] r;
        for (int op = 0; op < 6; op++) begin
            r = ref_tt(op);
            for (int ab = 0; ab < 4; ab++) begin
                g_op = 3'(op);
                g_a = ab[1];
                g_b = ab[0];
                #1;
                checks++;
                if (g_y !== r[ab]) begin
                    errors++;
                    $display("FAIL golden op=%0d ab=%02b: got %b want %b", op, 2'(ab), g_y, r[ab]);
                end
            end
        end
    endtask

    task automatic test_nand_correct();
        tt[0] = 4'b0111;
        sweep(0, 1'b0, "nand_ok");
    endtask

    task automatic test_nand_stuck0();
        tt[0] = 4'b0000;
        sweep(0, 1'b0, "nand_sa0");
    endtask

    task automatic test_nor_two_pass_midstart();
        tt[1] = 4'b0001;
        sweep(1, 1'b1, "nor_midstart");
    endtask

    task automatic test_reset_midrun();
        tt[0] = 4'b0000;
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        repeat (4) tick();
        checks++;
        if ({a_w[0], b_w[0]} !== 2'b10 || fc[0] !== 4'd2) begin
            errors++;
            $display("FAIL rst_mid pre: ab=%b%b fc=%0d, want ab=10 fc=2", a_w[0], b_w[0], fc[0]);
        end
        rst_v[0] = 1'b1;
        tick();
        rst_v[0] = 1'b0;
        checks++;
        if ({busy_w[0], done_w[0], pass_w[0], a_w[0], b_w[0], ff_w[0], fc[0]} !== 12'h000) begin
            errors++;
            $display("FAIL rst_mid clear: busy=%b done=%b pass=%b ab=%b%b ff=%b fc=%0d, want all 0",
                     busy_w[0], done_w[0], pass_w[0], a_w[0], b_w[0], ff_w[0], fc[0]);
        end
        for (int c = 0; c < 12; c++) begin
            tick();
            checks++;
            if (done_w[0] !== 1'b0 || busy_w[0] !== 1'b0) begin
                errors++;
                $display("FAIL rst_mid idle %0d: done=%b busy=%b, want 0 0", c, done_w[0], busy_w[0]);
            end
        end
        tt[0] = 4'b0111;
        sweep(0, 1'b0, "rst_mid_rerun");
    endtask

    // XOR gate checked against an XNOR golden; start held high across DONE.
    task automatic test_back_to_back();
        int total, waited;
        bit seen;
        total = 4 * n_of(2) * (s_of(2) + 1);
        tt[2] = 4'b0110;
        start_v[2] = 1'b1;
        tick();
        repeat (total) tick();
        checks++;
        if (done_w[2] !== 1'b1 || fc[2] !== 4'd4 || pass_w[2] !== 1'b0) begin
            errors++;
            $display("FAIL b2b first done: done=%b fc=%0d pass=%b, want 1 4 0", done_w[2], fc[2], pass_w[2]);
        end
        tick();
        checks++;
        if (busy_w[2] !== 1'b0 || done_w[2] !== 1'b0) begin
            errors++;
            $display("FAIL b2b idle gap: busy=%b done=%b, want 0 0", busy_w[2], done_w[2]);
        end
        tick();
        start_v[2] = 1'b0;
        checks++;
        if (busy_w[2] !== 1'b1 || fc[2] !== 4'd0 || {a_w[2], b_w[2]} !== 2'b00) begin
            errors++;
            $display("FAIL b2b restart: busy=%b fc=%0d ab=%b%b, want 1 0 00", busy_w[2], fc[2], a_w[2], b_w[2]);
        end
        seen = 1'b0;
        waited = 1;
        while (!seen && waited < 100) begin
            if (done_w[2] === 1'b1) seen = 1'b1;
            else begin
                tick();
                waited++;
            end
        end
        checks++;
        if (!seen || waited != total + 1) begin
            errors++;
            $display("FAIL b2b second done: seen=%b at cycle %0d, want seen=1 at cycle %0d", seen, waited, total + 1);
        end
        checks++;
        if (fc[2] !== 4'd4 || pass_w[2] !== 1'b0) begin
            errors++;
            $display("FAIL b2b second result: fc=%0d pass=%b, want 4 0", fc[2], pass_w[2]);
        end
        tick();
    endtask

    task automatic test_random();
        int k;
        for (int i = 0; i < 6; i++) begin
            k = $urandom_range(0, NI - 1);
            tt[k] = 4'($urandom_range(0, 15));
            sweep(k, 1'($urandom_range(0, 1)), "random");
        end
    endtask

    initial begin
        for (int k = 0; k < NI; k++) begin
            rst_v[k] = 1'b1;
            start_v[k] = 1'b0;
            tt[k] = 4'b0000;
        end
        g_op = 3'd0;
        g_a = 1'b0;
        g_b = 1'b0;
        test_reset();
        test_golden_unit();
        test_nand_correct();
        test_nand_stuck0();
        test_nor_two_pass_midstart();
        test_reset_midrun();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
